// File: rtl/reset_domain_responder_if.sv
// Control/status bundle between the central reset controller
// and one per-domain reset_domain_responder.
interface reset_domain_responder_if;
    logic sync_rst_in;
    logic init_in;
    logic clk_en_in;
    logic local_rst_req;
    logic local_init_done;
    logic sync_rst_trigger_out;
    logic local_sync_rst_out;
    logic local_init_out;
    logic local_clk_en_out;
    logic domain_ready_out;
    logic init_timeout_out;

    modport master (
        output sync_rst_in,
        output init_in,
        output clk_en_in,
        output local_rst_req,
        output local_init_done,
        input  sync_rst_trigger_out,
        input  local_sync_rst_out,
        input  local_init_out,
        input  local_clk_en_out,
        input  domain_ready_out,
        input  init_timeout_out
    );

    modport slave (
        input  sync_rst_in,
        input  init_in,
        input  clk_en_in,
        input  local_rst_req,
        input  local_init_done,
        output sync_rst_trigger_out,
        output local_sync_rst_out,
        output local_init_out,
        output local_clk_en_out,
        output domain_ready_out,
        output init_timeout_out
    );
endinterface

// File: rtl/reset_domain_responder.sv
// Per-domain reset endpoint: stretches the controller reset,
// runs local init under a timeout and reports ready/fault.
module reset_domain_responder #(
    parameter int RESETHOLDCYCLES   = 16,
    parameter int INITTIMEOUTCYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    async_rst_in,
    reset_domain_responder_if.slave bus
);

    localparam int HW = $clog2(RESETHOLDCYCLES + 1);
    localparam int TW = $clog2(INITTIMEOUTCYCLES + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(RESETHOLDCYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(INITTIMEOUTCYCLES - 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_HOLD,
        S_WAITINIT,
        S_INIT,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [HW-1:0] r_hcnt;
    logic [HW-1:0] w_hcnt;
    logic [TW-1:0] r_tcnt;
    logic [TW-1:0] w_tcnt;
    logic          r_req;
    logic          w_req;

    logic          r_trig;
    logic          r_lsr;
    logic          r_linit;
    logic          r_clken;
    logic          r_ready;
    logic          r_tmo;

    // Next state, counter updates and the held reset request
    always_comb begin
        w_next = r_state;
        w_hcnt = r_hcnt;
        w_tcnt = r_tcnt;
        w_req  = r_req |
                 (bus.local_rst_req && (r_state != S_RESET));
        if (bus.sync_rst_in) begin
            // Controller reset wins over everything and
            // acknowledges any pending local request.
            w_next = S_RESET;
            w_hcnt = '0;
            w_tcnt = '0;
            w_req  = 1'b0;
        end else begin
            unique case (r_state)
                S_RESET: begin
                    w_hcnt = '0;
                    w_next = S_HOLD;
                end
                S_HOLD: begin
                    if (r_hcnt == HOLD_LAST) begin
                        w_next = S_WAITINIT;
                    end else if (r_hcnt != '1) begin
                        w_hcnt = r_hcnt + HW'(1);
                    end
                end
                S_WAITINIT: begin
                    if (bus.init_in) begin
                        w_next = S_INIT;
                        w_tcnt = '0;
                    end
                end
                S_INIT: begin
                    // Completion beats timeout in the same cycle
                    if (bus.local_init_done) begin
                        w_next = S_RUN;
                    end else if (r_tcnt == TMO_LAST) begin
                        w_next = S_FAULT;
                    end else if (r_tcnt != '1) begin
                        w_tcnt = r_tcnt + TW'(1);
                    end
                end
                S_RUN, S_FAULT: begin
                end
                default: begin
                    w_next = S_RESET;
                end
            endcase
        end
    end

    // State, counters and request latch
    always_ff @(posedge clk or negedge async_rst_in) begin
        if (!async_rst_in) begin
            r_state <= S_RESET;
            r_hcnt  <= '0;
            r_tcnt  <= '0;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hcnt  <= w_hcnt;
            r_tcnt  <= w_tcnt;
            r_req   <= w_req;
        end
    end

    // Registered outputs decoded from the upcoming state
    always_ff @(posedge clk or negedge async_rst_in) begin
        if (!async_rst_in) begin
            r_trig  <= 1'b0;
            r_lsr   <= 1'b1;
            r_linit <= 1'b0;
            r_clken <= 1'b0;
            r_ready <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_trig  <= w_req | (w_next == S_FAULT);
            r_lsr   <= (w_next == S_RESET) |
                       (w_next == S_HOLD);
            r_linit <= (w_next == S_INIT);
            r_clken <= (w_next == S_RUN) & bus.clk_en_in;
            r_ready <= (w_next == S_RUN);
            r_tmo   <= (w_next == S_FAULT);
        end
    end

    assign bus.sync_rst_trigger_out = r_trig;
    assign bus.local_sync_rst_out   = r_lsr;
    assign bus.local_init_out       = r_linit;
    assign bus.local_clk_en_out     = r_clken;
    assign bus.domain_ready_out     = r_ready;
    assign bus.init_timeout_out     = r_tmo;

endmodule

// File: tb/tb_reset_domain_responder.sv
// Scoreboard bench for reset_domain_responder: directed
// bring-up scenarios followed by randomized control traffic.
module tb_reset_domain_responder;

    localparam int H = 16;
    localparam int T = 12;

    localparam int PH_RESET   = 0;
    localparam int PH_STRETCH = 1;
    localparam int PH_AWAIT   = 2;
    localparam int PH_INIT    = 3;
    localparam int PH_RUN     = 4;
    localparam int PH_FAULT   = 5;

    logic clk = 1'b0;
    logic arst = 1'b0;

    int checks = 0;
    int errors = 0;

    // model of the responder, phrased as remaining/used cycles
    int m_ph   = PH_RESET;
    int m_left = 0;
    int m_used = 0;
    bit m_req  = 1'b0;
    bit m_en   = 1'b0;

    logic [5:0] q[$];

    always #5 clk = ~clk;

    reset_domain_responder_if ifc();

    reset_domain_responder #(
        .RESETHOLDCYCLES   (H),
        .INITTIMEOUTCYCLES (T)
    ) dut (
        .clk          (clk),
        .async_rst_in (arst),
        .bus          (ifc)
    );

    function automatic logic [5:0] m_out();
        return {m_req || (m_ph == PH_FAULT),
                (m_ph == PH_RESET) || (m_ph == PH_STRETCH),
                m_ph == PH_INIT,
                m_en,
                m_ph == PH_RUN,
                m_ph == PH_FAULT};
    endfunction

    function automatic logic [5:0] dut_out();
        return {ifc.sync_rst_trigger_out,
                ifc.local_sync_rst_out,
                ifc.local_init_out,
                ifc.local_clk_en_out,
                ifc.domain_ready_out,
                ifc.init_timeout_out};
    endfunction

    task automatic m_reset();
        m_ph   = PH_RESET;
        m_left = 0;
        m_used = 0;
        m_req  = 1'b0;
        m_en   = 1'b0;
    endtask

    task automatic m_step(input bit s, i, e, r, d);
        bit nreq;
        nreq = s ? 1'b0 : (m_req || (r && m_ph != PH_RESET));
        if (s) begin
            m_ph = PH_RESET;
        end else begin
            case (m_ph)
                PH_RESET: begin
                    m_ph   = PH_STRETCH;
                    m_left = H - 1;
                end
                PH_STRETCH: begin
                    if (m_left == 0) m_ph = PH_AWAIT;
                    else m_left--;
                end
                PH_AWAIT: begin
                    if (i) begin
                        m_ph   = PH_INIT;
                        m_used = 1;
                    end
                end
                PH_INIT: begin
                    if (d) m_ph = PH_RUN;
                    else if (m_used == T) m_ph = PH_FAULT;
                    else m_used++;
                end
                default: ;
            endcase
        end
        m_req = nreq;
        m_en  = (m_ph == PH_RUN) && e;
    endtask

    task automatic check(input string nm,
                         input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b exp=%b",
                     nm, $time, got, exp);
        end
    endtask

    task automatic check_all(input logic [5:0] g,
                             input logic [5:0] e);
        check("sync_rst_trigger_out", g[5], e[5]);
        check("local_sync_rst_out",   g[4], e[4]);
        check("local_init_out",       g[3], e[3]);
        check("local_clk_en_out",     g[2], e[2]);
        check("domain_ready_out",     g[1], e[1]);
        check("init_timeout_out",     g[0], e[0]);
    endtask

    // one cycle of stimulus; expected result queued for monitor
    task automatic cyc(input bit a, s, i, e, r, d);
        @(negedge clk);
        arst                = a;
        ifc.sync_rst_in     = s;
        ifc.init_in         = i;
        ifc.clk_en_in       = e;
        ifc.local_rst_req   = r;
        ifc.local_init_done = d;
        if (!a) m_reset();
        else m_step(s, i, e, r, d);
        q.push_back(m_out());
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic srst(input int n);
        repeat (n) cyc(1, 1, 0, 0, 0, 0);
    endtask

    task automatic bringup(input int dly);
        cyc(1, 0, 1, 0, 0, 0);
        idle(dly - 1);
        cyc(1, 0, 0, 1, 0, 1);
    endtask

    // monitor: compare each registered output update
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_all(dut_out(), e);
            end
        end
    end

    initial begin
        bit en;
        // power-up
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        srst(5);
        idle(H + 3);
        // normal bring-up, clock enable tracking
        bringup(10);
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 0, k[0] ^ k[2], 0, 0);
        end
        // local request held until controller reset
        cyc(1, 0, 0, 1, 1, 0);
        repeat (19) cyc(1, 0, 0, 1, 0, 0);
        srst(1);
        idle(H + 2);
        // init timeout then clear by controller reset
        cyc(1, 0, 1, 0, 0, 0);
        idle(T + 4);
        cyc(1, 0, 0, 0, 1, 0);
        idle(3);
        srst(1);
        idle(4);
        // mid-hold reset restarts the stretch
        srst(2);
        idle(8);
        srst(2);
        idle(H + 2);
        // completion exactly at the timeout boundary wins
        bringup(T);
        idle(3);
        // async reset in RUN, checked between clock edges
        @(posedge clk);
        #3;
        arst = 1'b0;
        m_reset();
        #1;
        check_all(dut_out(), m_out());
        repeat (2) cyc(0, 0, 0, 1, 0, 0);
        idle(H + 3);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            en = 1'($urandom);
            cyc($urandom_range(0, 499) != 0,
                $urandom_range(0, 59) == 0,
                $urandom_range(0, 3) == 0,
                en,
                $urandom_range(0, 79) == 0,
                $urandom_range(0, 14) == 0);
        end
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d need=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
